// File: rtl/multiword_add_seq.sv
// Multi-beat wide adder: one DATA_WIDTH slice per beat, carry held between beats.
// Results leave through a registered valid/ready stage with word index and final carry.
module multiword_add_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WORDS  = 4,
    localparam int IW = $clog2(MAX_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_last,
    output logic                  out_carry,
    output logic [IW-1:0]         out_idx,
    output logic                  busy,
    output logic                  len_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_WORDS - 1);

    state_t              state_q;
    state_t              state_d;
    logic                carry_q;
    logic                carry_d;
    logic [IW-1:0]       cnt_q;
    logic [IW-1:0]       cnt_d;

    logic                acc;
    logic                at_limit;
    logic                end_op;
    logic                overflow;
    logic [DATA_WIDTH:0] sum_w;

    // carry_q is zero whenever the FSM is IDLE, so no state gating is needed here
    assign sum_w = {1'b0, in_a} + {1'b0, in_b} + {{DATA_WIDTH{1'b0}}, carry_q};

    assign acc      = in_valid & in_ready;
    assign at_limit = (state_q == RUN) && (cnt_q == LAST_IDX);
    assign end_op   = in_last | at_limit;
    assign overflow = acc & at_limit & ~in_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (acc) begin
            if (end_op) begin
                state_d = IDLE;
                carry_d = 1'b0;
                cnt_d   = '0;
            end else begin
                state_d = RUN;
                carry_d = sum_w[DATA_WIDTH];
                cnt_d   = cnt_q + IW'(1);
            end
        end
    end

    always_comb begin
        busy     = (state_q == RUN);
        in_ready = ~out_valid | out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_carry <= 1'b0;
            out_idx   <= '0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_sum   <= sum_w[DATA_WIDTH-1:0];
            out_carry <= sum_w[DATA_WIDTH];
            out_idx   <= cnt_q;
            out_last  <= end_op;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_err <= 1'b0;
        end else if (overflow) begin
            len_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed literal checks plus randomized ops
// compared against a prefix-sum model of the wide addition.
module tb_multiword_add_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_carry;
    logic [1:0] out_idx;
    logic       busy;
    logic       len_err;

    multiword_add_seq #(.DATA_WIDTH(8), .MAX_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_last(out_last), .out_carry(out_carry),
        .out_idx(out_idx), .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       l;
        logic [1:0] i;
    } exp_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t q[$];
    logic [7:0] ca[4];
    logic [7:0] cb[4];
    int   cn = 0;
    logic len_exp = 1'b0;
    bit   checking = 1'b0;
    bit   rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Word i of an operation is byte i of (A+B) over the words seen so far.
    function automatic void model_accept(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic last);
        longint unsigned sa = 0;
        longint unsigned sb = 0;
        longint unsigned s;
        exp_t e;
        ca[cn] = a;
        cb[cn] = b;
        for (int j = 0; j <= cn; j++) begin
            sa = sa | (64'(ca[j]) << (8 * j));
            sb = sb | (64'(cb[j]) << (8 * j));
        end
        s   = sa + sb;
        e.s = 8'(s >> (8 * cn));
        e.c = s[8 * (cn + 1)];
        e.l = last || (cn == 3);
        e.i = 2'(cn);
        if (cn == 3 && !last) len_exp = 1'b1;
        q.push_back(e);
        cn = e.l ? 0 : cn + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is aligned 1 time unit after a rising edge.
    task automatic send_word(input logic [7:0] a, input logic [7:0] b,
                             input logic last);
        bit ok = 1'b0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (ok) model_accept(a, b, last);
        else chk("accept_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cn = 0;
        q.delete();
        len_exp = 1'b0;
    endtask

    always @(negedge clk) begin
        if (checking && !rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_word", 1, 0);
                end else begin
                    chk("sum", out_sum, q[0].s);
                    chk("carry", out_carry, q[0].c);
                    chk("last", out_last, q[0].l);
                    chk("idx", out_idx, q[0].i);
                    if (out_ready) q.delete(0);
                end
            end
            chk("busy", busy, cn != 0);
            chk("len_err", len_err, len_exp);
        end
    end

    initial begin
        forever begin
            step();
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_carry", out_carry, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_in_ready", in_ready, 1);
        checking  = 1'b1;
        out_ready = 1'b1;
        step();

        // single word with carry out
        send_word(8'h80, 8'h80, 1'b1);
        @(negedge clk);
        chk("t1_sum", out_sum, 8'h00);
        chk("t1_carry", out_carry, 1);
        chk("t1_last", out_last, 1);
        chk("t1_idx", out_idx, 0);
        chk("t1_busy", busy, 0);
        step();

        // carry chain across two words
        send_word(8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        chk("t2a_sum", out_sum, 8'h00);
        chk("t2a_carry", out_carry, 1);
        chk("t2a_idx", out_idx, 0);
        chk("t2a_last", out_last, 0);
        chk("t2a_busy", busy, 1);
        step();
        send_word(8'h00, 8'h00, 1'b1);
        @(negedge clk);
        chk("t2b_sum", out_sum, 8'h01);
        chk("t2b_carry", out_carry, 0);
        chk("t2b_idx", out_idx, 1);
        chk("t2b_last", out_last, 1);
        step();

        // backpressure
        out_ready = 1'b0;
        send_word(8'h10, 8'h20, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_in_ready_low", in_ready, 0);
            chk("t3_held_valid", out_valid, 1);
            chk("t3_held_sum", out_sum, 8'h30);
        end
        step();
        fork
            send_word(8'h05, 8'h06, 1'b1);
            begin
                step();
                out_ready = 1'b1;
                @(negedge clk);
                chk("t3_in_ready_release", in_ready, 1);
            end
        join
        @(negedge clk);
        chk("t3_second_sum", out_sum, 8'h0B);
        step();

        // length overflow: five beats without in_last
        for (int k = 0; k < 4; k++) send_word(8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        chk("t4_idx3", out_idx, 3);
        chk("t4_sum3", out_sum, 8'h01);
        chk("t4_forced_last", out_last, 1);
        chk("t4_len_err", len_err, 1);
        chk("t4_busy_idle", busy, 0);
        step();
        send_word(8'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk("t4_restart_idx", out_idx, 0);
        chk("t4_restart_sum", out_sum, 8'h00);
        chk("t4_restart_last", out_last, 0);
        step();
        send_word(8'h00, 8'h00, 1'b1);

        // reset in the middle of an operation
        send_word(8'h11, 8'h22, 1'b0);
        send_word(8'h33, 8'h44, 1'b0);
        do_reset();
        @(negedge clk);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_idx", out_idx, 0);
        chk("t5_len_err", len_err, 0);
        step();
        send_word(8'h01, 8'h01, 1'b1);
        @(negedge clk);
        chk("t5_sum", out_sum, 8'h02);
        chk("t5_carry", out_carry, 0);
        chk("t5_idx_fresh", out_idx, 0);
        chk("t5_last", out_last, 1);
        step();

        // randomized back-to-back operations
        rnd_ready = 1'b1;
        for (int op = 0; op < 80; op++) begin
            int  n;
            bit  ovf;
            ovf = ($urandom_range(0, 9) == 0);
            n   = ovf ? 5 : int'($urandom_range(1, 4));
            for (int w = 0; w < n; w++) begin
                logic [7:0] a;
                logic [7:0] b;
                a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                b = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'($urandom);
                repeat ($urandom_range(0, 2)) step();
                send_word(a, b, !ovf && (w == n - 1));
            end
        end
        rnd_ready = 1'b0;
        step();
        out_ready = 1'b1;
        for (int t = 0; t < 50 && q.size() != 0; t++) step();
        chk("drain_empty", q.size(), 0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
